serial_ripple_subtractor: RTL and testbench

Bit-serial ripple subtractor that computes D = A − B − Bin_in one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation, sequential companion of the combinational 4-bit ripple-carry adder. It gives the arithmetic datapath an area-minimal subtract unit with a start/done handshake. It sits beside the adder and is driven by the same kind of stimulus: operand pair plus incoming borrow.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_ripple_subtractor.sv | 96 +++++++++
 tb/tb_serial_ripple_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial ripple subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // ceil(log2(width)), never below 1, so the bit counter can index 0..width-1
    function automatic int cnt_width(input int width);
        int w;
        w = 1;
        while ((1 << w) < width) w++;
        return w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit combinational full subtractor: d = a - b - bin, bout = borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor D = A - B - Bin_in, LSB first, one full-subtractor cell.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin_in,
    output logic [WIDTH-1:0] D,
    output logic             Bout_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_next;

    full_subtractor u_full_subtractor (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            D        <= '0;
            Bout_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        br       <= Bin_in;
                        cnt      <= '0;
                        D        <= '0;
                        Bout_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        ovf      <= 1'b0;
`endif
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    D    <= {d_bit, D[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        Bout_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the shift registers' LSBs are the original MSBs.
                        ovf      <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor with a result scoreboard.
// Define SERIAL_SUB_OVF_EN to also check the signed-overflow flag.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin_in;
    logic [W-1:0] D;
    logic         Bout_out;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Bin_in   (Bin_in),
        .D        (D),
        .Bout_out (Bout_out),
        .busy     (busy),
        .done     (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t         e;
        logic [W:0]   diff;
        diff   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d    = diff[W-1:0];
        e.bout = diff[W];
        e.ovf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.d[W-1]);
        return e;
    endfunction

    task automatic score();
        exp_t e;
        check("sb_level", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("D", 32'(D), 32'(e.d));
            check("Bout_out", 32'(Bout_out), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    // One operation; ignore_at > 0 pulses start with other operands into that edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int ignore_at);
        int done_cnt;
        int done_cyc;
        exp_t e;
        done_cnt = 0;
        done_cyc = -1;
        wait_idle();
        A = a; B = b; Bin_in = bin; start = 1'b1;
        e = model(a, b, bin);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_edge0", 32'(busy), 1);
        for (int k = 1; k <= W + 2; k++) begin
            if (k == ignore_at) begin
                A = ~a; B = a; Bin_in = ~bin; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = k;
                score();
            end
            if (k == W) check("busy_at_done", 32'(busy), 1);
            if (k == W + 1) check("busy_fall", 32'(busy), 0);
            if (k == W + 2) check("D_hold", 32'(D), 32'(e.d));
        end
        check("done_count", 32'(done_cnt), 1);
        check("done_cycle", 32'(done_cyc), W);
    endtask

    initial begin
        logic [W-1:0] ta[7] = '{4'b0101, 4'b0000, 4'b1111, 4'b1001, 4'b1000, 4'b0011, 4'b0000};
        logic [W-1:0] tb[7] = '{4'b0010, 4'b0001, 4'b1111, 4'b0100, 4'b0001, 4'b0001, 4'b0000};
        logic         tbin[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int           done_cnt;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_D", 32'(D), 0);
        check("rst_Bout", 32'(Bout_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_op(ta[i], tb[i], tbin[i], 0);

        // start pulsed mid-operation must be ignored
        run_op(4'b0110, 4'b0011, 1'b0, 2);

        for (int i = 0; i < 6; i++)
            run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                   1'($urandom_range(0, 1)), 0);

        // reset asserted mid-operation aborts with no done
        wait_idle();
        A = 4'b0111; B = 4'b0010; Bin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_D", 32'(D), 0);
        check("abort_Bout", 32'(Bout_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 0);
        run_op(4'b1100, 4'b0101, 1'b0, 0);

        // start held high re-arms on every IDLE cycle
        wait_idle();
        A = 4'b1010; B = 4'b0011; Bin_in = 1'b1; start = 1'b1;
        sb.push_back(model(4'b1010, 4'b0011, 1'b1));
        sb.push_back(model(4'b1010, 4'b0011, 1'b1));
        done_cnt = 0;
        for (int k = 0; k <= 2 * W + 3; k++) begin
            @(posedge clk); #1;
            if (k == 2 * W + 3) start = 1'b0;
            if (done) begin
                done_cnt++;
                score();
            end
        end
        check("held_start_dones", 32'(done_cnt), 2);
        check("held_start_idle", 32'(busy), 0);

        check("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
